// File: rtl/atoi_arbiter_if.sv
// Bundle of requester, converter and result signals shared by the ATOI arbiter.
// The arbiter connects through the slave modport; the environment driving
// requesters and the converter uses the master modport.
interface atoi_arbiter_if #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 64
);
  logic                    req0;
  logic                    req1;
  logic [INPUT_WIDTH-1:0]  data0;
  logic [INPUT_WIDTH-1:0]  data1;
  logic                    sop0;
  logic                    sop1;
  logic                    eop0;
  logic                    eop1;
  logic                    gnt0;
  logic                    gnt1;
  logic [INPUT_WIDTH-1:0]  cv_data;
  logic                    cv_sop;
  logic                    cv_eop;
  logic [OUTPUT_WIDTH-1:0] cv_number;
  logic                    cv_valid;
  logic                    cv_error;
  logic [OUTPUT_WIDTH-1:0] number;
  logic                    valid;
  logic                    error;
  logic                    timeout;
  logic                    owner;

  modport slave (
    input  req0, req1, data0, data1, sop0, sop1, eop0, eop1,
    input  cv_number, cv_valid, cv_error,
    output gnt0, gnt1, cv_data, cv_sop, cv_eop,
    output number, valid, error, timeout, owner
  );

  modport master (
    output req0, req1, data0, data1, sop0, sop1, eop0, eop1,
    output cv_number, cv_valid, cv_error,
    input  gnt0, gnt1, cv_data, cv_sop, cv_eop,
    input  number, valid, error, timeout, owner
  );
endinterface

// File: rtl/atoi_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ASCII-to-integer
// converter. Grants one whole packet at a time, forwards its beats with one
// cycle of latency, then waits (bounded) for the converter result and returns
// it tagged with the owning requester.
module atoi_arbiter #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 64,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic clk,
  input  logic rst,
  atoi_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_RES
  } state_t;

  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT);

  state_t                  state_q;
  logic                    rr_q;
  logic                    owner_q;
  logic                    gnt0_q;
  logic                    gnt1_q;
  logic [7:0]              cnt_q;
  logic [INPUT_WIDTH-1:0]  cv_data_q;
  logic                    cv_sop_q;
  logic                    cv_eop_q;
  logic [OUTPUT_WIDTH-1:0] number_q;
  logic                    valid_q;
  logic                    error_q;
  logic                    timeout_q;

  logic                    win_d;
  logic [INPUT_WIDTH-1:0]  sel_data_d;
  logic                    sel_sop_d;
  logic                    sel_eop_d;

  // Winner selection (rr breaks ties) and beat mux from the granted port.
  always_comb begin
    win_d = bus.req1;
    if (bus.req0 && bus.req1) begin
      win_d = rr_q;
    end
    sel_data_d = bus.data0;
    sel_sop_d  = bus.sop0;
    sel_eop_d  = bus.eop0;
    if (owner_q) begin
      sel_data_d = bus.data1;
      sel_sop_d  = bus.sop1;
      sel_eop_d  = bus.eop1;
    end
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      cnt_q     <= '0;
      cv_data_q <= '0;
      cv_sop_q  <= 1'b0;
      cv_eop_q  <= 1'b0;
      number_q  <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      cv_sop_q  <= 1'b0;
      cv_eop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_q <= win_d;
            gnt0_q  <= ~win_d;
            gnt1_q  <= win_d;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          cv_data_q <= sel_data_d;
          cv_sop_q  <= sel_sop_d;
          cv_eop_q  <= sel_eop_d;
          if (sel_eop_d) begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= TIMEOUT_LD;
            state_q <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (bus.cv_valid || bus.cv_error) begin
            number_q <= bus.cv_number;
            valid_q  <= bus.cv_valid;
            error_q  <= bus.cv_error;
            rr_q     <= ~rr_q;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else if (cnt_q < 8'd2) begin
            // Last waiting cycle: the pulse lands exactly TIMEOUT cycles after entry.
            number_q  <= '0;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
            rr_q      <= ~rr_q;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.cv_data = cv_data_q;
  assign bus.cv_sop  = cv_sop_q;
  assign bus.cv_eop  = cv_eop_q;
  assign bus.number  = number_q;
  assign bus.valid   = valid_q;
  assign bus.error   = error_q;
  assign bus.timeout = timeout_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_atoi_arbiter.sv
// Directed bench for atoi_arbiter: a small base/digit model predicts each
// converter result, expected results are queued when a packet is sent and
// popped when the arbiter raises valid/error.
module tb_atoi_arbiter;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 64;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [63:0] number;
    logic        valid;
    logic        error;
    logic        timeout;
    logic        owner;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  atoi_arbiter_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

  atoi_arbiter #(
    .INPUT_WIDTH (IW),
    .OUTPUT_WIDTH(OW),
    .TIMEOUT     (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: digits 0-9/A-Z, anything not below base is an error.
  function automatic void model(input logic [15:0] base, input string s,
                                output logic [63:0] v, output bit e);
    v = '0;
    e = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      int c;
      int d;
      c = int'(s[i]);
      if (c >= 48 && c <= 57)      d = c - 48;
      else if (c >= 65 && c <= 90) d = c - 55;
      else                         d = 99;
      if (d >= int'(base)) e = 1'b1;
      else                 v = v * 64'(base) + 64'(d);
    end
  endfunction

  task automatic drive_port(input int who, input logic [15:0] d, input logic s, input logic e);
    if (who == 0) begin
      bus.data0 = d; bus.sop0 = s; bus.eop0 = e;
    end else begin
      bus.data1 = d; bus.sop1 = s; bus.eop1 = e;
    end
  endtask

  task automatic set_req(input int who, input logic v);
    if (who == 0) bus.req0 = v;
    else          bus.req1 = v;
  endtask

  // mode 0: converter answers dly cycles into WAIT_RES; 1: never answers;
  // 2: reset asserted dly cycles into WAIT_RES.
  task automatic send_pkt(input int who, input logic [15:0] base, input string digits,
                          input int mode, input int dly, input bit keep_req,
                          input bit drop_mid, input bit spurious);
    int          n;
    int          lat;
    bit          seen;
    bit          err;
    logic [63:0] val;
    logic [15:0] beat;
    logic        own_gnt;
    res_t        e;
    model(base, digits, val, err);
    set_req(who, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      own_gnt = (who == 0) ? bus.gnt0 : bus.gnt1;
      if (own_gnt) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("grant_seen", 64'(seen), 64'd1);
    chk("owner_at_grant", 64'(bus.owner), 64'(who));
    chk("other_gnt_low", 64'((who == 0) ? bus.gnt1 : bus.gnt0), 64'd0);
    n = digits.len() + 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0) beat = base;
      else        beat = {8'h00, digits[i-1]};
      drive_port(who, beat, i == 0, i == n - 1);
      drive_port(1 - who, ~beat, 1'b1, 1'b1);
      if (drop_mid && i == 1) set_req(who, 1'b0);
      if (i == n - 1 && !keep_req) set_req(who, 1'b0);
      if (spurious && i == 1) begin
        bus.cv_valid  = 1'b1;
        bus.cv_number = 64'hDEAD;
      end
      @(posedge clk); #1;
      bus.cv_valid = 1'b0;
      chk("cv_data", 64'(bus.cv_data), 64'(beat));
      chk("cv_sop", 64'(bus.cv_sop), 64'(i == 0));
      chk("cv_eop", 64'(bus.cv_eop), 64'(i == n - 1));
      own_gnt = (who == 0) ? bus.gnt0 : bus.gnt1;
      chk("gnt_hold", 64'(own_gnt), 64'(i < n - 1));
    end
    drive_port(0, '0, 1'b0, 1'b0);
    drive_port(1, '0, 1'b0, 1'b0);

    if (mode == 2) begin
      repeat (dly) begin @(posedge clk); #1; end
      #2 rst = 1'b0;
      #1;
      chk("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
      chk("rst_cv", 64'({bus.cv_data, bus.cv_sop, bus.cv_eop}), 64'd0);
      chk("rst_number", bus.number, 64'd0);
      chk("rst_flags", 64'({bus.valid, bus.error, bus.timeout, bus.owner}), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_no_pulse", 64'({bus.valid, bus.error, bus.gnt0, bus.gnt1}), 64'd0);
      rst = 1'b1;
      return;
    end

    if (mode == 0) e = '{number: err ? 64'd0 : val, valid: !err, error: err, timeout: 1'b0, owner: who[0]};
    else           e = '{number: 64'd0, valid: 1'b0, error: 1'b1, timeout: 1'b1, owner: who[0]};
    sb.push_back(e);

    seen = 1'b0;
    lat  = 0;
    for (int k = 0; k < int'(TO) + 4; k++) begin
      if (mode == 0 && k == dly) begin
        bus.cv_number = err ? 64'd0 : val;
        bus.cv_valid  = !err;
        bus.cv_error  = err;
      end
      @(posedge clk); #1;
      bus.cv_valid = 1'b0;
      bus.cv_error = 1'b0;
      if (bus.valid || bus.error) begin
        seen = 1'b1;
        lat  = k + 1;
        break;
      end
    end
    chk("result_seen", 64'(seen), 64'd1);
    chk("result_latency", 64'(lat), 64'((mode == 0) ? dly + 1 : int'(TO)));
    chk("idle_gap_gnt", 64'(bus.gnt0 | bus.gnt1), 64'd0);
    @(posedge clk); #1;
    chk("flags_clear", 64'({bus.valid, bus.error, bus.timeout}), 64'd0);
    chk("number_hold", bus.number, e.number);
  endtask

  // Result scoreboard and grant exclusivity, sampled away from the clock edge.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.gnt0 && bus.gnt1) chk("gnt_exclusive", 64'd1, 64'd0);
      if (bus.valid || bus.error) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          res_t e;
          e = sb.pop_front();
          chk("res_number", bus.number, e.number);
          chk("res_valid", 64'(bus.valid), 64'(e.valid));
          chk("res_error", 64'(bus.error), 64'(e.error));
          chk("res_timeout", 64'(bus.timeout), 64'(e.timeout));
          chk("res_owner", 64'(bus.owner), 64'(e.owner));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    drive_port(0, '0, 1'b0, 1'b0);
    drive_port(1, '0, 1'b0, 1'b0);
    bus.cv_number = '0; bus.cv_valid = 1'b0; bus.cv_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
    chk("reset_cv", 64'({bus.cv_data, bus.cv_sop, bus.cv_eop}), 64'd0);
    chk("reset_number", bus.number, 64'd0);
    chk("reset_flags", 64'({bus.valid, bus.error, bus.timeout, bus.owner}), 64'd0);

    // Both requesting out of reset: 0, then 1 (tie with rr=1), then 0.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst = 1'b1;
    send_pkt(0, 16'd10, "163", 0, 2, 1'b1, 1'b0, 1'b0);
    send_pkt(1, 16'd10, "42", 0, 1, 1'b0, 1'b0, 1'b0);
    send_pkt(0, 16'd16, "FF", 0, 0, 1'b0, 1'b0, 1'b0);
    // Single requester wins with rr pointing away; stray cv_valid during STREAM.
    send_pkt(0, 16'd10, "163", 0, 3, 1'b0, 1'b0, 1'b1);
    // Invalid digit, converter flags error in the eop-forward cycle.
    send_pkt(1, 16'd12, ";72", 0, 0, 1'b0, 1'b0, 1'b0);
    // Single-beat packet (sop and eop together).
    send_pkt(0, 16'd10, "", 0, 1, 1'b0, 1'b0, 1'b0);
    // Converter never answers.
    send_pkt(1, 16'd10, "9", 1, 0, 1'b0, 1'b0, 1'b0);
    // Request dropped mid-packet.
    send_pkt(0, 16'd10, "1234", 0, 2, 1'b0, 1'b1, 1'b0);
    // Reset during WAIT_RES, then a fresh packet.
    send_pkt(1, 16'd10, "77", 2, 3, 1'b0, 1'b0, 1'b0);
    send_pkt(0, 16'd8, "17", 0, 1, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
